quad_encoder_decoder: RTL

Parametrised quadrature encoder front end for the pendulum controller. Synchronises and debounces the A/B/Z encoder lines, performs 4x decoding, and maintains a position count that wraps modulo the counts-per-revolution selected by PR, plus a signed revolution count. Also measures velocity as signed counts per window (window length selected by R) and flags illegal transitions. Sits between the encoder pins and the PWM/drive control logic inside EE_TOP.

---
 rtl/quad_enc_pkg.sv | 48 ++++
 rtl/quad_input_filter.sv | 51 +++++
 rtl/quad_encoder_decoder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/quad_enc_pkg.sv
// ============================================================================
// quad_enc_pkg: shared types and helpers for the quadrature encoder front end
// Rev 1.0
// ============================================================================
`default_nettype none

package quad_enc_pkg;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_ERR  = 2'd2,
    STEP_REV  = 2'd3
  } step_e;

  function automatic logic [10:0] ppr_of(input logic [3:0] pr);
    logic [10:0] ppr;
    case (pr)
      4'd0:    ppr = 11'd1024;
      4'd1:    ppr = 11'd512;
      4'd2:    ppr = 11'd500;
      4'd3:    ppr = 11'd400;
      4'd4:    ppr = 11'd360;
      4'd5:    ppr = 11'd256;
      4'd6:    ppr = 11'd200;
      4'd7:    ppr = 11'd100;
      4'd8:    ppr = 11'd1000;
      4'd9:    ppr = 11'd600;
      default: ppr = 11'd1024;
    endcase
    return ppr;
  endfunction

  // Map {A,B} onto its position in the forward cycle 00->10->11->01.
  function automatic logic [1:0] phase_of(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  // Phase difference mod 4: 0 none, 1 forward, 2 both bits flipped, 3 reverse.
  function automatic step_e decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic [1:0] d;
    d = phase_of(cur_ab) - phase_of(prev_ab);
    return step_e'(d);
  endfunction

endpackage

`default_nettype wire

// File: rtl/quad_input_filter.sv
// ============================================================================
// quad_input_filter: 2-flop synchroniser followed by a FILT_LEN-sample filter
// Rev 1.0
// ============================================================================
`default_nettype none

module quad_input_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic             sync1_q, sync2_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample matching the current level restarts the run count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) filt_d = sync2_q;
      else                   cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = filt_q;

endmodule

`default_nettype wire

// File: rtl/quad_encoder_decoder.sv
// ============================================================================
// quad_encoder_decoder: 4x quadrature decode, position/rev count, velocity
// Rev 1.0
// ============================================================================
`default_nettype none

module quad_encoder_decoder
  import quad_enc_pkg::*;
#(
  parameter int POS_W      = 16,
  parameter int VEL_W      = 16,
  parameter int REV_W      = 16,
  parameter int FILT_LEN   = 3,
  parameter int BASE_TICKS = 4000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       PR,
  input  logic [2:0]       R,
  input  logic             A,
  input  logic             B,
  input  logic             Z,
  input  logic             index_en,
  input  logic             clr,
  output logic [POS_W-1:0] pos,
  output logic [REV_W-1:0] rev,
  output logic             dir,
  output logic             step,
  output logic [VEL_W-1:0] vel,
  output logic             vel_valid,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam int WIN_W = $clog2(BASE_TICKS) + 7;
  localparam int ACC_W = (WIN_W > VEL_W) ? WIN_W + 1 : VEL_W + 1;
  localparam logic signed [ACC_W-1:0] VMAX = ACC_W'((1 << (VEL_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] VMIN = -VMAX;

  logic [2:0] raw_in, filt;
  assign raw_in = {Z, B, A};

  for (genvar i = 0; i < 3; i++) begin : g_filt
    quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt (
      .clk  (clk),
      .reset(reset),
      .din  (raw_in[i]),
      .dout (filt[i])
    );
  end

  logic [1:0]              ab_prev_q, ab_prev_d;
  logic                    z_prev_q;
  logic                    cfg_ok_q;
  logic [3:0]              pr_q;
  logic [POS_W-1:0]        cpr_max_q, cpr_max_d;
  logic [2:0]              r_q;
  logic [WIN_W-1:0]        win_q, win_d, win_last;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum, step_val, sat_val;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic [REV_W-1:0]        rev_q, rev_d;
  logic                    dir_q, dir_d, step_q, step_d, err_q, err_d;
  logic [VEL_W-1:0]        vel_q, vel_d;
  logic                    vel_valid_q, vel_valid_d;
  logic [7:0]              err_cnt_q, err_cnt_d;

  step_e st;
  logic  fwd, bwd, cfg_chg, z_rise;

  always_comb begin
    ab_prev_d = {filt[0], filt[1]};
    st        = decode_step(ab_prev_q, ab_prev_d);
    fwd       = (st == STEP_FWD);
    bwd       = (st == STEP_REV);
    // Until the first clock after reset no CPR has been loaded yet.
    cfg_chg   = !cfg_ok_q || (PR != pr_q);
    z_rise    = filt[2] & ~z_prev_q;
    cpr_max_d = cfg_chg ? POS_W'({ppr_of(PR), 2'b00} - 13'd1) : cpr_max_q;

    pos_d = pos_q;
    rev_d = rev_q;
    if (clr || cfg_chg) begin
      pos_d = '0;
      rev_d = '0;
    end else if (index_en && z_rise) begin
      pos_d = '0;
    end else if (fwd) begin
      if (pos_q == cpr_max_q) begin
        pos_d = '0;
        rev_d = rev_q + REV_W'(1);
      end else begin
        pos_d = pos_q + POS_W'(1);
      end
    end else if (bwd) begin
      if (pos_q == '0) begin
        pos_d = cpr_max_q;
        rev_d = rev_q - REV_W'(1);
      end else begin
        pos_d = pos_q - POS_W'(1);
      end
    end

    dir_d     = (fwd || bwd) ? fwd : dir_q;
    step_d    = fwd || bwd;
    err_d     = (st == STEP_ERR);
    err_cnt_d = err_cnt_q;
    if (clr)                             err_cnt_d = '0;
    else if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;

    step_val = fwd ? ACC_W'(1) : (bwd ? '1 : '0);
    acc_sum  = acc_q + step_val;
    if (acc_sum > VMAX)      sat_val = VMAX;
    else if (acc_sum < VMIN) sat_val = VMIN;
    else                     sat_val = acc_sum;

    win_last    = (WIN_W'(BASE_TICKS) << r_q) - WIN_W'(1);
    vel_d       = vel_q;
    vel_valid_d = 1'b0;
    acc_d       = acc_sum;
    win_d       = win_q + WIN_W'(1);
    if (clr || (R != r_q)) begin
      acc_d = '0;
      win_d = '0;
    end else if (win_q == win_last) begin
      vel_d       = sat_val[VEL_W-1:0];
      vel_valid_d = 1'b1;
      acc_d       = '0;
      win_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ab_prev_q   <= 2'b00;
      z_prev_q    <= 1'b0;
      cfg_ok_q    <= 1'b0;
      pr_q        <= '0;
      cpr_max_q   <= '0;
      r_q         <= '0;
      win_q       <= '0;
      acc_q       <= '0;
      pos_q       <= '0;
      rev_q       <= '0;
      dir_q       <= 1'b0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
      vel_q       <= '0;
      vel_valid_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      ab_prev_q   <= ab_prev_d;
      z_prev_q    <= filt[2];
      cfg_ok_q    <= 1'b1;
      pr_q        <= PR;
      cpr_max_q   <= cpr_max_d;
      r_q         <= R;
      win_q       <= win_d;
      acc_q       <= acc_d;
      pos_q       <= pos_d;
      rev_q       <= rev_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      err_q       <= err_d;
      vel_q       <= vel_d;
      vel_valid_q <= vel_valid_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign pos       = pos_q;
  assign rev       = rev_q;
  assign dir       = dir_q;
  assign step      = step_q;
  assign vel       = vel_q;
  assign vel_valid = vel_valid_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire
